spi_arb_ctrl: RTL and testbench
===============================

# spi_arb_ctrl

Shared-bus SPI master controller. It arbitrates between NREQ requesters for a single SPI bus and drives one active-low slave select per requester. It also generates SCK from the system clock and runs one full-duplex SIZE-bit mode-0 transfer per grant. It sits between on-chip clients and the off-chip SPI pins, replacing per-client free-running masters.

## Interface
- SIZE, 8: bits per transfer (2..32).
- NREQ, 4: requester count / slave-select count (2..8).
- FCLK, 50000000: system clock frequency, Hz.
- SPEED, 9600: SCK frequency, Hz; half-period HALF = (FCLK/SPEED)/2-1, so one SCK phase T = HALF+1 clk cycles.
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester transfer request, level, held until done.
- tx_data  in  NREQ*SIZE  per-requester transmit word; slice i = bits [i*SIZE +: SIZE], MSB first.
- gnt  out  NREQ  one-hot grant, high from grant cycle through done cycle.
- busy  out  1  high whenever the FSM is not IDLE.
- done  out  1  one-cycle pulse; rx_data valid in that cycle and held until the next done.
- rx_data  out  SIZE  word received from miso during the granted transfer.
- sck  out  1  SPI clock, idle low.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- ss_n  out  NREQ  active-low slave selects; ss_n[i] low only while gnt[i] is high.

## Operation
- The FSM has five states.
  - IDLE: if any req bit is set, pick the winner, latch its tx_data slice into the shift register, set gnt[w], drive ss_n[w] low and mosi to the word MSB, then go to SETUP.
  - SETUP: hold for T cycles with sck low, then go to SHIFT.
  - SHIFT: toggle sck every T cycles.
    - On each cycle that drives sck 0→1, shift miso into the receive register.
    - On each cycle that drives sck 1→0, shift the next tx bit onto mosi.
    - After SIZE rising and SIZE falling edges, go to HOLD.
  - HOLD: T cycles with sck low and ss_n still asserted. On the last cycle: pulse done, load rx_data, clear gnt, release ss_n, then go to GAP.
  - GAP: T cycles with all ss_n high, then go to IDLE.
- Arbitration is round-robin: the search starts at (last winner + 1) mod NREQ. After reset, "last winner" is NREQ-1, so index 0 has first priority.
- req is sampled only in IDLE. Dropping req mid-transfer does not abort; the transfer completes and done still pulses. tx_data changes after the grant cycle are ignored.
- When simultaneous requests arrive, exactly one is granted; the rest wait and are served in rotation order.
- Reset values (also on reset mid-transfer): gnt=0, busy=0, done=0, rx_data=0, sck=0, mosi=0, ss_n=all ones, state IDLE. The partial transfer is discarded.

## Timing
- Latency from req rising to gnt/ss_n low is 1 clk (registered decision in IDLE).
- From grant to done is (2*SIZE+2)*T clk cycles.
- From done to the earliest next grant is T+1 clk cycles (GAP plus the IDLE decision).
- The first sck rising edge occurs T cycles after ss_n falls. mosi is stable for T cycles on each side of every rising edge.
- miso is sampled in the clk cycle in which sck is registered high. The slave must present data before that edge.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Configuration
- SPI_ARB_FIXED_PRIO_EN defined: fixed priority replaces round-robin. The lowest set req index always wins and the last-winner register is not built.
- SPI_ARB_FIXED_PRIO_EN undefined: round-robin as described above.

## Structure
- Package spi_arb_pkg holds the FSM state enum (IDLE, SETUP, SHIFT, HOLD, GAP) and a function computing HALF from FCLK and SPEED.
- Sub-module spi_xfer_engine contains the phase counter, sck toggle, tx/rx shift registers and edge counter. The controller starts it with a load pulse and receives an end-of-SHIFT indication from it.
- Arbitration and the ss_n/gnt logic stay in spi_arb_ctrl.

## Test plan
All scenarios use FCLK=8, SPEED=2, so HALF=1 and T=2.
1. Reset check: assert rst mid-SHIFT → next cycle ss_n=4'b1111, sck=0, gnt=0, busy=0, and no done pulse.
2. Single request: req=4'b0010, tx slice 1 = 8'hA5, slave returns 8'h3C → ss_n=4'b1101 one cycle after req. mosi shows 1,0,1,0,0,1,0,1 at the sck rising edges. done fires 36 clk after the grant with rx_data=8'h3C.
3. Round-robin: req=4'b1111 held → grants 0,1,2,3,0 in order, each ss_n low only for its own transfer. Grants are separated by T+1=3 clk after done.
4. Request drop: req[2] deasserted two cycles after its grant → the transfer completes and done still pulses with gnt=4'b0100.
5. Boundary data: tx=8'hFF with miso held 0, then tx=8'h00 with miso held 1 → rx_data=8'h00, then 8'hFF. sck shows exactly 8 rising edges per transfer.
6. With SPI_ARB_FIXED_PRIO_EN defined: req=4'b1001 held → index 0 is granted repeatedly and index 3 is never granted.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the arbitrated SPI master.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    // SCK half-period count; one SCK phase lasts calc_half() + 1 clk cycles.
    function automatic int unsigned calc_half(input int unsigned fclk, input int unsigned speed);
        return (fclk / speed) / 2 - 1;
    endfunction

endpackage

// File: rtl/spi_xfer_engine.sv
// Mode-0 SPI shift engine: phase counter, SCK generation, tx/rx shift registers, edge count.
module spi_xfer_engine #(
    parameter int unsigned SIZE = 8,
    parameter int unsigned HALF = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [SIZE-1:0] tx_word_i,
    input  logic            run_i,
    input  logic            setup_i,
    input  logic            shift_i,
    input  logic            miso_i,
    output logic            tick_o,
    output logic            shift_done_o,
    output logic            sck_o,
    output logic            mosi_o,
    output logic [SIZE-1:0] rx_word_o
);

    localparam int unsigned PW    = (HALF > 0) ? $clog2(HALF + 1) : 1;
    localparam int unsigned EDGES = 2 * SIZE;
    localparam int unsigned EW    = $clog2(EDGES + 1);

    logic [PW-1:0]   phase_q, phase_d;
    logic [EW-1:0]   edge_q, edge_d;
    logic            sck_q, sck_d;
    logic [SIZE-1:0] tx_q, tx_d;
    logic [SIZE-1:0] rx_q, rx_d;
    logic            tick;
    logic            toggle;

    always_comb begin
        tick         = (phase_q == PW'(HALF));
        // The SETUP tick makes the first rising edge; SHIFT then toggles until all edges are out.
        toggle       = tick && (setup_i || (shift_i && (edge_q != EW'(EDGES))));
        shift_done_o = shift_i && tick && (edge_q == EW'(EDGES));
        phase_d      = (run_i && !tick) ? phase_q + 1'b1 : '0;

        sck_d  = sck_q;
        edge_d = edge_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        if (load_i) begin
            sck_d  = 1'b0;
            edge_d = '0;
            tx_d   = tx_word_i;
            rx_d   = '0;
        end else if (toggle) begin
            sck_d  = ~sck_q;
            edge_d = edge_q + 1'b1;
            if (!sck_q) begin
                rx_d = {rx_q[SIZE-2:0], miso_i};
            end else begin
                tx_d = {tx_q[SIZE-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            edge_q  <= '0;
            sck_q   <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            phase_q <= phase_d;
            edge_q  <= edge_d;
            sck_q   <= sck_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end

    assign tick_o    = tick;
    assign sck_o     = sck_q;
    assign mosi_o    = tx_q[SIZE-1];
    assign rx_word_o = rx_q;

endmodule

// File: rtl/spi_arb_ctrl.sv
// Shared-bus SPI master: round-robin arbitration, grant/slave-select and transfer sequencing.
// Define SPI_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module spi_arb_ctrl
    import spi_arb_pkg::*;
#(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned FCLK  = 50000000,
    parameter int unsigned SPEED = 9600
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SIZE-1:0] tx_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 done,
    output logic [SIZE-1:0]      rx_data,
    output logic                 sck,
    output logic                 mosi,
    input  logic                 miso,
    output logic [NREQ-1:0]      ss_n
);

    localparam int unsigned HALF = calc_half(FCLK, SPEED);
    localparam int unsigned IW   = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ss_n_q, ss_n_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [SIZE-1:0] rx_data_q, rx_data_d;

    logic            found;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] win_oh;
    logic [SIZE-1:0] tx_sel;
    logic            load;
    logic            tick;
    logic            shift_done;
    logic [SIZE-1:0] rx_word;

`ifdef SPI_ARB_FIXED_PRIO_EN
    always_comb begin
        found   = |req;
        win_idx = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req[IW'(i)]) begin
                win_idx = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] last_q, last_d;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        int unsigned cand;
        logic [IW-1:0] cand_idx;
        found   = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            cand     = (int'(last_q) + k) % NREQ;
            cand_idx = IW'(cand);
            if (!found && req[cand_idx]) begin
                found   = 1'b1;
                win_idx = cand_idx;
            end
        end
    end
`endif

    always_comb begin
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
        tx_sel          = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (IW'(i) == win_idx) begin
                tx_sel = tx_data[i*SIZE +: SIZE];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ss_n_d    = ss_n_q;
        done_d    = 1'b0;
        rx_data_d = rx_data_q;
        load      = 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
        last_d    = last_q;
`endif
        // gnt stays up through the done cycle and drops right after it.
        if (done_q) begin
            gnt_d = '0;
        end
        case (state_q)
            StIdle: begin
                if (found) begin
                    load    = 1'b1;
                    gnt_d   = win_oh;
                    ss_n_d  = ~win_oh;
                    state_d = StSetup;
`ifndef SPI_ARB_FIXED_PRIO_EN
                    last_d  = win_idx;
`endif
                end
            end
            StSetup: begin
                if (tick) state_d = StShift;
            end
            StShift: begin
                if (shift_done) state_d = StHold;
            end
            StHold: begin
                if (tick) begin
                    done_d    = 1'b1;
                    rx_data_d = rx_word;
                    ss_n_d    = '1;
                    state_d   = StGap;
                end
            end
            StGap: begin
                if (tick) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            ss_n_q    <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            last_q    <= IW'(NREQ - 1);
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ss_n_q    <= ss_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
`ifndef SPI_ARB_FIXED_PRIO_EN
            last_q    <= last_d;
`endif
        end
    end

    spi_xfer_engine #(
        .SIZE (SIZE),
        .HALF (HALF)
    ) u_engine (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load),
        .tx_word_i    (tx_sel),
        .run_i        (state_q != StIdle),
        .setup_i      (state_q == StSetup),
        .shift_i      (state_q == StShift),
        .miso_i       (miso),
        .tick_o       (tick),
        .shift_done_o (shift_done),
        .sck_o        (sck),
        .mosi_o       (mosi),
        .rx_word_o    (rx_word)
    );

    assign gnt     = gnt_q;
    assign ss_n    = ss_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_arb_ctrl.sv
// Directed scoreboard bench for spi_arb_ctrl with FCLK=8, SPEED=2 (T=2 clk per SCK phase).
module tb_spi_arb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [7:0]  tx_tbl[4];
    logic [7:0]  slave_tbl[4];
    logic        slave_idle = 1'b0;
    logic [31:0] tx_data;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [7:0]  rx_data;
    logic        sck;
    logic        mosi;
    logic        miso = 1'b0;
    logic [3:0]  ss_n;

    typedef struct {
        int         idx;
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int model_last = 3;

    // Bus monitor / slave model state
    int         grant_cyc = 0;
    int         rises = 0;
    int         bitcnt = 7;
    logic [7:0] mosi_cap = 8'h00;
    logic       ss_viol = 1'b0;
    logic       sck_prev = 1'b0;
    logic [3:0] gnt_prev = 4'b0000;

    assign tx_data = {tx_tbl[3], tx_tbl[2], tx_tbl[1], tx_tbl[0]};

    spi_arb_ctrl #(
        .SIZE  (8),
        .NREQ  (4),
        .FCLK  (8),
        .SPEED (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .tx_data (tx_data),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .sck     (sck),
        .mosi    (mosi),
        .miso    (miso),
        .ss_n    (ss_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [1:0] sel;
        logic [7:0] w;
        sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!ss_n[i]) sel = 2'(i);
        end
        w = slave_tbl[sel];
        if (gnt != 4'b0000 && gnt_prev == 4'b0000) begin
            grant_cyc <= cyc;
            rises     <= 0;
            mosi_cap  <= 8'h00;
            ss_viol   <= 1'b0;
        end
        if (sck && !sck_prev) begin
            rises    <= rises + 1;
            mosi_cap <= {mosi_cap[6:0], mosi};
        end
        if (((~ss_n) & (~gnt)) != 4'b0000) ss_viol <= 1'b1;
        if (&ss_n) begin
            bitcnt <= 7;
            miso   <= slave_idle;
        end else if (!sck && sck_prev && bitcnt > 0) begin
            bitcnt <= bitcnt - 1;
            miso   <= w[3'(bitcnt - 1)];
        end else begin
            miso   <= w[3'(bitcnt)];
        end
        sck_prev <= sck;
        gnt_prev <= gnt;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
`ifdef SPI_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) begin
            if (r[i]) return i;
        end
        return last;
`else
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] j;
            j = 2'((last + k) % 4);
            if (r[j]) return int'(j);
        end
        return last;
`endif
    endfunction

    // Predicts the next winner for request pattern r and queues its expected result.
    task automatic push(input logic [3:0] r);
        exp_t e;
        int   w;
        w     = pick(r, model_last);
        e.idx = w;
        e.tx  = tx_tbl[w];
        e.rx  = slave_tbl[w];
        sb.push_back(e);
        model_last = w;
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        while (gnt === 4'b0000 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("grant_seen", {31'b0, |gnt}, 32'd1);
    endtask

    task automatic expect_done(input bit b2b);
        exp_t       e;
        logic [3:0] oh;
        int         n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            check("done_seen", {31'b0, done}, 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            check("sb_has_entry", 32'(sb.size()), 32'd1);
            return;
        end
        e  = sb.pop_front();
        oh = 4'b0001 << e.idx;
        check("gnt_at_done", {28'b0, gnt}, {28'b0, oh});
        check("rx_data", {24'b0, rx_data}, {24'b0, e.rx});
        check("mosi_word", {24'b0, mosi_cap}, {24'b0, e.tx});
        check("sck_rises", rises, 32'd8);
        check("grant_to_done", cyc - grant_cyc, 32'd36);
        check("ss_only_gnt", {31'b0, ss_viol}, 32'd0);
        if (b2b) check("done_to_grant", grant_cyc - last_done_cyc, 32'd3);
        last_done_cyc = cyc;
        @(negedge clk);
        check("done_pulse", {31'b0, done}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            tx_tbl[i]    = 8'h00;
            slave_tbl[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("rst_ss_n", {28'b0, ss_n}, 32'hF);
        check("rst_gnt", {28'b0, gnt}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_sck", {31'b0, sck}, 32'd0);
        check("rst_mosi", {31'b0, mosi}, 32'd0);
        check("rst_rx_data", {24'b0, rx_data}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single request, one-cycle grant latency
        tx_tbl[1]    = 8'hA5;
        slave_tbl[1] = 8'h3C;
        push(4'b0010);
        req = 4'b0010;
        @(negedge clk);
        check("grant_ss_n", {28'b0, ss_n}, 32'hD);
        check("grant_gnt", {28'b0, gnt}, 32'h2);
        check("grant_busy", {31'b0, busy}, 32'd1);
        expect_done(1'b0);
        req = 4'b0000;

        // Reset in the middle of SHIFT
        req = 4'b0001;
        repeat (14) @(negedge clk);
        check("pre_rst_active", {28'b0, ss_n}, 32'hE);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        check("midrst_ss_n", {28'b0, ss_n}, 32'hF);
        check("midrst_sck", {31'b0, sck}, 32'd0);
        check("midrst_gnt", {28'b0, gnt}, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_rx_data", {24'b0, rx_data}, 32'h0);
        @(negedge clk);
        check("midrst_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        model_last = 3;
        repeat (2) @(negedge clk);

        // All four requesting: rotation order from reset
        tx_tbl    = '{8'h11, 8'h22, 8'h33, 8'h44};
        slave_tbl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        for (int i = 0; i < 5; i++) push(4'b1111);
        req = 4'b1111;
        expect_done(1'b0);
        for (int i = 0; i < 4; i++) expect_done(1'b1);
        req = 4'b0000;

        // Request dropped mid-transfer; late tx_data change ignored
        tx_tbl[2]    = 8'h5A;
        slave_tbl[2] = 8'h96;
        push(4'b0100);
        req = 4'b0100;
        wait_grant();
        repeat (2) @(negedge clk);
        req       = 4'b0000;
        tx_tbl[2] = 8'h00;
        expect_done(1'b0);

        // Boundary data words
        tx_tbl[0]    = 8'hFF;
        slave_tbl[0] = 8'h00;
        slave_idle   = 1'b0;
        push(4'b0001);
        req = 4'b0001;
        expect_done(1'b0);
        req          = 4'b0000;
        tx_tbl[0]    = 8'h00;
        slave_tbl[0] = 8'hFF;
        slave_idle   = 1'b1;
        push(4'b0001);
        req = 4'b0001;
        expect_done(1'b0);
        req        = 4'b0000;
        slave_idle = 1'b0;

        // Requesters 0 and 3 held together
        tx_tbl[0]    = 8'h81;
        tx_tbl[3]    = 8'h7E;
        slave_tbl[0] = 8'hE7;
        slave_tbl[3] = 8'h18;
        push(4'b1001);
        push(4'b1001);
        req = 4'b1001;
        expect_done(1'b0);
        expect_done(1'b1);
        req = 4'b0000;

        repeat (6) @(negedge clk);
        check("final_busy", {31'b0, busy}, 32'd0);
        check("final_ss_n", {28'b0, ss_n}, 32'hF);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
